// File: rtl/rx_flag_destuff_if.sv
// Bus between the HDLC serial line and the receive front end.
// The master drives the line and the enable. The slave (rx_flag_destuff) drives the status and octets.
interface rx_flag_destuff_if;
  logic       Rx;
  logic       RxEN;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_AbortSignal;
  logic       Rx_ValidFrame;
  logic       Rx_EoF;
  logic       Rx_FrameErr;
  logic       Rx_NewByte;
  logic [7:0] Rx_Byte;

  modport master (
    output Rx, RxEN,
    input  Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame,
           Rx_EoF, Rx_FrameErr, Rx_NewByte, Rx_Byte
  );

  modport slave (
    input  Rx, RxEN,
    output Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame,
           Rx_EoF, Rx_FrameErr, Rx_NewByte, Rx_Byte
  );
endinterface

// File: rtl/rx_flag_destuff.sv
// HDLC receive front end. It detects flags and aborts, removes stuffed zeros and assembles octets LSB-first.
// Three registered stages: the input shift register, the pattern match, then the frame FSM and datapath.
module rx_flag_destuff (
  input  logic             Clk,
  input  logic             Rst,
  rx_flag_destuff_if.slave rx_if
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] FRAME = 2'd2;

  logic [7:0] sr_q, sr_d;
  logic       flag_q, flag_d;
  logic       abort_q, abort_d;
  logic       bit_q, bit_d;
  logic [1:0] state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] acc_q, acc_d;
  logic       got_byte_q, got_byte_d;
  logic       eof_q, eof_d;
  logic       err_q, err_d;
  logic       abort_sig_q, abort_sig_d;
  logic       new_byte_q, new_byte_d;
  logic [7:0] byte_q, byte_d;

  always_comb begin
    sr_d        = sr_q;
    flag_d      = flag_q;
    abort_d     = abort_q;
    bit_d       = bit_q;
    state_d     = state_q;
    skip_d      = skip_q;
    ones_d      = ones_q;
    bitcnt_d    = bitcnt_q;
    acc_d       = acc_q;
    got_byte_d  = got_byte_q;
    byte_d      = byte_q;
    eof_d       = 1'b0;
    err_d       = 1'b0;
    abort_sig_d = 1'b0;
    new_byte_d  = 1'b0;

    if (!rx_if.RxEN) begin
      sr_d       = 8'h00;
      flag_d     = 1'b0;
      abort_d    = 1'b0;
      bit_d      = 1'b0;
      state_d    = IDLE;
      skip_d     = 3'd0;
      ones_d     = 3'd0;
      bitcnt_d   = 3'd0;
      acc_d      = 8'h00;
      got_byte_d = 1'b0;
    end else begin
      sr_d    = {sr_q[6:0], rx_if.Rx};
      flag_d  = (sr_q == 8'h7E);
      abort_d = (sr_q == 8'h7F);
      bit_d   = sr_q[7];

      if (flag_q) begin
        // bit_q holds the flag's first bit; the skip count hides the other seven.
        skip_d = 3'd7;
        ones_d = 3'd0;
        if (state_q == IDLE) begin
          state_d = ARMED;
        end else if (state_q == FRAME) begin
          eof_d      = 1'b1;
          err_d      = (bitcnt_q != 3'd0) || !got_byte_q;
          bitcnt_d   = 3'd0;
          acc_d      = 8'h00;
          got_byte_d = 1'b0;
          state_d    = ARMED;
        end
      end else begin
        if (skip_q != 3'd0) begin
          skip_d = skip_q - 3'd1;
        end else if (state_q != IDLE) begin
          if (!bit_q && (ones_q == 3'd5)) begin
            ones_d = 3'd0;
          end else begin
            ones_d = bit_q ? ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1) : 3'd0;
            acc_d  = {bit_q, acc_q[7:1]};
            if (bitcnt_q == 3'd7) begin
              bitcnt_d   = 3'd0;
              byte_d     = {bit_q, acc_q[7:1]};
              new_byte_d = 1'b1;
              got_byte_d = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
            end
            if (state_q == ARMED) state_d = FRAME;
          end
        end

        // This overrides the data path. A byte completed by the abort's own leading zero is still delivered.
        if (abort_q) begin
          ones_d      = 3'd0;
          bitcnt_d    = 3'd0;
          acc_d       = 8'h00;
          got_byte_d  = 1'b0;
          state_d     = IDLE;
          abort_sig_d = (state_q == FRAME);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sr_q        <= 8'h00;
      flag_q      <= 1'b0;
      abort_q     <= 1'b0;
      bit_q       <= 1'b0;
      state_q     <= IDLE;
      skip_q      <= 3'd0;
      ones_q      <= 3'd0;
      bitcnt_q    <= 3'd0;
      acc_q       <= 8'h00;
      got_byte_q  <= 1'b0;
      eof_q       <= 1'b0;
      err_q       <= 1'b0;
      abort_sig_q <= 1'b0;
      new_byte_q  <= 1'b0;
      byte_q      <= 8'h00;
    end else begin
      sr_q        <= sr_d;
      flag_q      <= flag_d;
      abort_q     <= abort_d;
      bit_q       <= bit_d;
      state_q     <= state_d;
      skip_q      <= skip_d;
      ones_q      <= ones_d;
      bitcnt_q    <= bitcnt_d;
      acc_q       <= acc_d;
      got_byte_q  <= got_byte_d;
      eof_q       <= eof_d;
      err_q       <= err_d;
      abort_sig_q <= abort_sig_d;
      new_byte_q  <= new_byte_d;
      byte_q      <= byte_d;
    end
  end

  assign rx_if.Rx_FlagDetect  = flag_q;
  assign rx_if.Rx_AbortDetect = abort_q;
  assign rx_if.Rx_AbortSignal = abort_sig_q;
  assign rx_if.Rx_ValidFrame  = (state_q == FRAME);
  assign rx_if.Rx_EoF         = eof_q;
  assign rx_if.Rx_FrameErr    = err_q;
  assign rx_if.Rx_NewByte     = new_byte_q;
  assign rx_if.Rx_Byte        = byte_q;

endmodule

// File: tb/tb_rx_flag_destuff.sv
// Bench for rx_flag_destuff. It first builds a line bit stream of directed and random frames.
// It then predicts, for each cycle, the output events from the frame contents and compares the DUT against them.
module tb_rx_flag_destuff;

  localparam int MAXC = 8192;

  logic clk;
  logic rst_n;
  rx_flag_destuff_if bus ();

  rx_flag_destuff dut (.Clk(clk), .Rst(rst_n), .rx_if(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit         rx_bits [MAXC];
  bit         rx_en   [MAXC];
  bit         e_flag  [MAXC];
  bit         e_abort [MAXC];
  bit         e_asig  [MAXC];
  bit         e_valid [MAXC];
  bit         e_eof   [MAXC];
  bit         e_err   [MAXC];
  bit         e_nb    [MAXC];
  logic [7:0] e_byte  [MAXC];

  int         n = 0;
  int         win = 0;
  bit         armed = 1'b0;
  int         d_idx = 0;
  int         nbits = 0;
  int         ones = 0;
  logic [7:0] cur = 8'h00;
  logic [7:0] exp_bytes[$];
  bit         exp_errs[$];

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] model_byte = 8'h00;

  // Each line bit is sampled at edge index n.
  // A completed flag or abort window is visible one edge later. RxEN low cancels everything still pending.
  task automatic push(input bit b, input bit en);
    if (n < MAXC - 32) begin
      rx_bits[n] = b;
      rx_en[n]   = en;
      if (en) begin
        win = ((win << 1) | int'(b)) & 8'hFF;
        if (win == 8'h7E) e_flag[n+1]  = 1'b1;
        if (win == 8'h7F) e_abort[n+1] = 1'b1;
      end else begin
        win = 0;
        for (int c = n; c < n + 16; c++) begin
          e_flag[c] = 0; e_abort[c] = 0; e_asig[c] = 0; e_valid[c] = 0;
          e_eof[c] = 0; e_err[c] = 0; e_nb[c] = 0;
        end
      end
      n++;
    end
  endtask

  task automatic set_valid(input int a, input int b);
    for (int c = a; c <= b; c++) e_valid[c] = 1'b1;
  endtask

  task automatic close_frame();
    nbits = 0; ones = 0; cur = 8'h00;
  endtask

  task automatic data_bit(input bit b);
    push(b, 1'b1);
    if (nbits == 0) d_idx = n - 1;
    cur[nbits % 8] = b;
    nbits++;
    if (nbits % 8 == 0) begin
      e_nb[n-1+9]   = 1'b1;
      e_byte[n-1+9] = cur;
      exp_bytes.push_back(cur);
      cur = 8'h00;
    end
    ones = b ? ones + 1 : 0;
    if (ones == 5) begin
      push(1'b0, 1'b1);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) data_bit(v[i]);
  endtask

  task automatic send_flag();
    bit pat [8];
    pat = '{0, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 8; i++) push(pat[i], 1'b1);
    if (nbits > 0) begin
      e_eof[n-1+2] = 1'b1;
      e_err[n-1+2] = (nbits % 8 != 0) || (nbits < 8);
      exp_errs.push_back((nbits % 8 != 0) || (nbits < 8));
      set_valid(d_idx + 9, n - 1 + 1);
    end
    close_frame();
    armed = 1'b1;
  endtask

  // The previous data bit must be the abort's leading zero.
  task automatic abort_tail();
    repeat (7) push(1'b1, 1'b1);
    if (nbits > 1) begin
      e_asig[n-1+2] = 1'b1;
      set_valid(d_idx + 9, n - 1 + 1);
    end
    close_frame();
    armed = 1'b0;
  endtask

  task automatic idle_ones(input int m);
    repeat (m) push(1'b1, 1'b1);
    if (m >= 8) armed = 1'b0;
  endtask

  task automatic zeros(input int m);
    repeat (m) push(1'b0, 1'b1);
  endtask

  task automatic disable_stretch(input int m);
    if (nbits > 0) set_valid(d_idx + 9, n - 1);
    close_frame();
    repeat (m) push(1'($urandom_range(0, 1)), 1'b0);
    armed = 1'b0;
  endtask

  task automatic check_bit(input string name, input int k, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %0b expected %0b", name, k, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_output(input int k);
    if (e_nb[k]) model_byte = e_byte[k];
    check_bit("flag_detect",  k, bus.Rx_FlagDetect,  e_flag[k]);
    check_bit("abort_detect", k, bus.Rx_AbortDetect, e_abort[k]);
    check_bit("abort_signal", k, bus.Rx_AbortSignal, e_asig[k]);
    check_bit("valid_frame",  k, bus.Rx_ValidFrame,  e_valid[k]);
    check_bit("eof",          k, bus.Rx_EoF,         e_eof[k]);
    check_bit("frame_err",    k, bus.Rx_FrameErr,    e_err[k]);
    check_bit("new_byte",     k, bus.Rx_NewByte,     e_nb[k]);
    compared++;
    if (bus.Rx_Byte !== model_byte) begin
      mismatched++;
      $display("[TB] FAIL rx_byte cycle %0d: got %02h expected %02h", k, bus.Rx_Byte, model_byte);
    end
  endtask

  task automatic apply_stimulus(input int k);
    bus.Rx   = rx_bits[k];
    bus.RxEN = rx_en[k];
  endtask

  int k4, s6, t6, cnt, first_ab, len, sel;
  logic [11:0] bits12;

  initial begin
    void'($urandom(32'h0BAD_F00D));

    // Directed part of the stream.
    idle_ones(20);
    zeros(3); send_flag(); send_byte(8'hA5); send_byte(8'h3C); send_flag(); idle_ones(10);
    zeros(2); send_flag(); send_byte(8'hFF); send_flag(); idle_ones(10);
    zeros(2); send_flag(); send_byte(8'h12); abort_tail(); k4 = n - 1; push(1'b0, 1'b1);
    idle_ones(3); zeros(2);
    bits12 = 12'h5A3;
    send_flag(); for (int i = 0; i < 12; i++) data_bit(bits12[i]); send_flag(); idle_ones(10);
    s6 = n;
    zeros(2); send_flag(); send_flag();
    for (int i = 0; i < 4; i++) data_bit(i % 2 == 0);
    disable_stretch(4);
    zeros(12);
    t6 = n;

    // Hand-computed pins on the model itself.
    first_ab = -1; cnt = 0;
    for (int c = 0; c <= 21; c++) if (e_abort[c]) begin cnt++; if (first_ab < 0) first_ab = c; end
    check_int("pin_idle_abort_count", cnt, 1);
    check_int("pin_idle_abort_cycle", first_ab, 7);
    check_int("pin_byte_count", exp_bytes.size(), 5);
    if (exp_bytes.size() >= 5) begin
      check_int("pin_byte0", exp_bytes[0], 8'hA5);
      check_int("pin_byte1", exp_bytes[1], 8'h3C);
      check_int("pin_byte2", exp_bytes[2], 8'hFF);
      check_int("pin_byte3", exp_bytes[3], 8'h12);
      check_int("pin_byte4", exp_bytes[4], 8'hA3);
    end
    check_int("pin_eof_count", exp_errs.size(), 3);
    if (exp_errs.size() >= 3) begin
      check_int("pin_err0", exp_errs[0], 0);
      check_int("pin_err1", exp_errs[1], 0);
      check_int("pin_err2", exp_errs[2], 1);
    end
    check_int("pin_abort_signal", e_asig[k4+2], 1);
    check_int("pin_abort_valid_before", e_valid[k4+1], 1);
    check_int("pin_abort_valid_after", e_valid[k4+2], 0);
    cnt = 0; for (int c = s6; c < t6; c++) cnt += int'(e_flag[c]);
    check_int("pin_seg6_flags", cnt, 2);
    cnt = 0; for (int c = s6; c < t6; c++) cnt += int'(e_eof[c]) + int'(e_nb[c]) + int'(e_valid[c]);
    check_int("pin_seg6_quiet", cnt, 0);

    // Random frames: stuffed data of random length, ended by a flag, an abort or a drop of RxEN.
    for (int f = 0; f < 40; f++) begin
      if (!armed) begin zeros($urandom_range(0, 4)); send_flag(); end
      if ($urandom_range(0, 3) == 0) send_flag();
      len = ($urandom_range(0, 1) == 1) ? 8 * $urandom_range(1, 4) : $urandom_range(1, 40);
      for (int i = 0; i < len; i++) data_bit($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 5);
      if (sel <= 3) begin
        send_flag();
        if ($urandom_range(0, 1) == 1) idle_ones($urandom_range(8, 12));
      end else if (sel == 4) begin
        data_bit(1'b0); abort_tail(); idle_ones($urandom_range(0, 4));
      end else begin
        disable_stretch($urandom_range(1, 4));
      end
    end
    if (armed) idle_ones(10);
    zeros(12);

    // Reset, then play the stream and compare on every falling edge.
    rst_n = 1'b0; bus.Rx = 1'b0; bus.RxEN = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_output(-1);
    end
    rst_n = 1'b1;
    for (int k = 0; k < n; k++) begin
      apply_stimulus(k);
      @(negedge clk);
      check_output(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
